// File: rtl/can_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : can_tx_serializer
//  Description : Serialises one standard-format CAN data frame (11-bit ID)
//                plus its CRC-15 onto the TX line, one bit per bit_tick.
//                Stuff bits are inserted from SOF through the last CRC bit.
//                The bus is sampled during the ACK slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module can_tx_serializer #(
   parameter int EOF_BITS  = 7,
   parameter int IFS_BITS  = 3,
   parameter int STUFF_LEN = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bit_tick,
   input  logic        start,
   input  logic [10:0] id,
   input  logic [3:0]  dlc,
   input  logic [63:0] data,
   input  logic [14:0] crc_in,
   input  logic        rx,
   output logic        tx,
   output logic        busy,
   output logic        done,
   output logic        ack_err
);

   localparam int RUN_W = $clog2(STUFF_LEN + 1);

   // Each state names the field of the bit that the next tick will send.
   // ST_IFS_END holds the last intermission bit until the tick that ends it.
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_SOF     = 4'd1,
      ST_ARB     = 4'd2,
      ST_CTRL    = 4'd3,
      ST_DATA    = 4'd4,
      ST_CRC     = 4'd5,
      ST_CRC_DEL = 4'd6,
      ST_ACK     = 4'd7,
      ST_ACK_DEL = 4'd8,
      ST_EOF     = 4'd9,
      ST_IFS     = 4'd10,
      ST_IFS_END = 4'd11
   } state_t;

   state_t           state_q, state_d;
   logic [6:0]       cnt_q, cnt_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             last_q, last_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ack_err_q, ack_err_d;
   logic [10:0]      id_q, id_d;
   logic [3:0]       dlc_q, dlc_d;
   logic [63:0]      data_q, data_d;
   logic [14:0]      crc_q, crc_d;

   logic             bit_val;
   state_t           adv_state;
   logic [6:0]       adv_cnt;
   logic [6:0]       data_bits;
   logic [3:0]       id_idx;
   logic [3:0]       crc_idx;
   logic [1:0]       dlc_idx;
   logic [5:0]       data_idx;
   logic             stuff_zone;
   logic             stuff_now;

   // dlc values above 8 still carry only 8 bytes
   assign data_bits = dlc_q[3] ? 7'd64 : {1'b0, dlc_q[2:0], 3'b000};

   // MSB-first bit indices within each latched field
   assign id_idx   = 4'd10 - cnt_q[3:0];
   assign crc_idx  = 4'd14 - cnt_q[3:0];
   assign dlc_idx  = 2'd3 - (cnt_q[1:0] - 2'd2);
   assign data_idx = 6'd63 - cnt_q[5:0];

   // A stuff bit may still be owed before CRC_DEL, so CRC_DEL is in the zone
   assign stuff_zone = state_q inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC, ST_CRC_DEL};
   assign stuff_now  = stuff_zone && (run_q == RUN_W'(STUFF_LEN));

   // Select the next frame bit and where the field pointer moves after it
   always_comb begin
      bit_val   = 1'b1;
      adv_state = state_q;
      adv_cnt   = cnt_q + 7'd1;
      case (state_q)
         ST_SOF: begin
            bit_val   = 1'b0;
            adv_state = ST_ARB;
            adv_cnt   = '0;
         end
         ST_ARB: begin
            if (cnt_q == 7'd11) begin
               bit_val   = 1'b0;                 // RTR
               adv_state = ST_CTRL;
               adv_cnt   = '0;
            end else begin
               bit_val = id_q[id_idx];
            end
         end
         ST_CTRL: begin
            bit_val = (cnt_q < 7'd2) ? 1'b0 : dlc_q[dlc_idx];   // IDE, r0, DLC
            if (cnt_q == 7'd5) begin
               adv_state = (dlc_q == 4'd0) ? ST_CRC : ST_DATA;
               adv_cnt   = '0;
            end
         end
         ST_DATA: begin
            bit_val = data_q[data_idx];
            if (cnt_q == data_bits - 7'd1) begin
               adv_state = ST_CRC;
               adv_cnt   = '0;
            end
         end
         ST_CRC: begin
            bit_val = crc_q[crc_idx];
            if (cnt_q == 7'd14) begin
               adv_state = ST_CRC_DEL;
               adv_cnt   = '0;
            end
         end
         ST_CRC_DEL: begin
            adv_state = ST_ACK;
            adv_cnt   = '0;
         end
         ST_ACK: begin
            adv_state = ST_ACK_DEL;
            adv_cnt   = '0;
         end
         ST_ACK_DEL: begin
            adv_state = ST_EOF;
            adv_cnt   = '0;
         end
         ST_EOF: begin
            if (cnt_q == 7'(EOF_BITS - 1)) begin
               adv_state = ST_IFS;
               adv_cnt   = '0;
            end
         end
         ST_IFS: begin
            if (cnt_q == 7'(IFS_BITS - 1)) begin
               adv_state = ST_IFS_END;
               adv_cnt   = '0;
            end
         end
         default: begin
            bit_val   = 1'b1;
            adv_state = state_q;
            adv_cnt   = cnt_q;
         end
      endcase
   end

   // Next-state: start acceptance, per-tick bit/stuff emission, completion
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      run_d     = run_q;
      last_d    = last_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ack_err_d = ack_err_q;
      id_d      = id_q;
      dlc_d     = dlc_q;
      data_d    = data_q;
      crc_d     = crc_q;

      if (!busy_q) begin
         if (start) begin
            id_d      = id;
            dlc_d     = dlc;
            data_d    = data;
            crc_d     = crc_in;
            busy_d    = 1'b1;
            ack_err_d = 1'b0;
            state_d   = ST_SOF;
            cnt_d     = '0;
            run_d     = '0;
            last_d    = 1'b0;
            tx_d      = 1'b1;
         end
      end else if (bit_tick) begin
         if (state_q == ST_IFS_END) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
         end else if (stuff_now) begin
            // Stuff bit: field pointer holds, run restarts with the stuff value
            tx_d   = ~last_q;
            last_d = ~last_q;
            run_d  = RUN_W'(1);
         end else begin
            tx_d    = bit_val;
            state_d = adv_state;
            cnt_d   = adv_cnt;
            if (state_q == ST_CRC_DEL) begin
               run_d = '0;
            end else if (stuff_zone) begin
               last_d = bit_val;
               run_d  = ((run_q != '0) && (bit_val == last_q)) ? run_q + RUN_W'(1) : RUN_W'(1);
            end
            // The tick loading ACK_DEL closes the ACK slot
            if ((state_q == ST_ACK_DEL) && rx) begin
               ack_err_d = 1'b1;
            end
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         run_q     <= '0;
         last_q    <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         id_q      <= '0;
         dlc_q     <= '0;
         data_q    <= '0;
         crc_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         run_q     <= run_d;
         last_q    <= last_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         id_q      <= id_d;
         dlc_q     <= dlc_d;
         data_q    <= data_d;
         crc_q     <= crc_d;
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ack_err = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_can_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_can_tx_serializer
//  Description : Scoreboard bench for can_tx_serializer. Stimulus pushes the
//                expected stuffed bit stream and frame results into queues; a
//                monitor pops and compares on every bit tick and done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_can_tx_serializer;

   localparam int EOF_BITS  = 7;
   localparam int IFS_BITS  = 3;
   localparam int STUFF_LEN = 5;
   localparam int TAIL_BITS = 3 + EOF_BITS + IFS_BITS;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        bit_tick = 1'b0;
   logic        start    = 1'b0;
   logic        rx       = 1'b0;
   logic [10:0] id       = '0;
   logic [3:0]  dlc      = '0;
   logic [63:0] data     = '0;
   logic [14:0] crc_in   = '0;
   logic        tx, busy, done, ack_err;

   can_tx_serializer #(
      .EOF_BITS  (EOF_BITS),
      .IFS_BITS  (IFS_BITS),
      .STUFF_LEN (STUFF_LEN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bit_tick (bit_tick),
      .start    (start),
      .id       (id),
      .dlc      (dlc),
      .data     (data),
      .crc_in   (crc_in),
      .rx       (rx),
      .tx       (tx),
      .busy     (busy),
      .done     (done),
      .ack_err  (ack_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int frames_done = 0;

   bit exp_bits[$];
   int exp_len[$];
   bit exp_ack[$];
   bit got[$];
   bit last_frame[$];
   bit ref_frame[$];
   bit model_raw[$];
   bit model_tx[$];
   bit destuffed[$];
   int model_stuff;

   // Tick spacing in cycles; 0 selects the rotating 1/3/17 pattern
   int spacing = 1;
   int pat[3] = '{1, 3, 17};
   int tick_cnt = 0;
   int pat_idx = 0;

   // bit_tick generator, driven on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         tick_cnt++;
         if (tick_cnt >= ((spacing == 0) ? pat[pat_idx] : spacing)) begin
            bit_tick = 1'b1;
            tick_cnt = 0;
            pat_idx  = (pat_idx + 1) % 3;
         end else begin
            bit_tick = 1'b0;
         end
      end
   end

   // Monitor: compare each emitted bit and each frame completion
   bit pre_tick, pre_busy, mon_eb, mon_ack;
   int mon_len;
   always @(posedge clk) begin
      pre_tick = bit_tick;
      pre_busy = busy;
      #1;
      if (rst) begin
         got.delete();
      end else begin
         if (pre_tick && pre_busy && busy) begin
            checks++;
            if (exp_bits.size() == 0) begin
               errors++;
               $display("FAIL tx_bit: got tx=%0b with no bit expected", tx);
            end else begin
               mon_eb = exp_bits.pop_front();
               if (tx !== mon_eb) begin
                  errors++;
                  $display("FAIL tx_bit[%0d]: got %0b expected %0b", got.size(), tx, mon_eb);
               end
            end
            got.push_back(tx);
         end
         if (done) begin
            checks++;
            if (exp_len.size() == 0) begin
               errors++;
               $display("FAIL done: unexpected done pulse");
            end else begin
               mon_len = exp_len.pop_front();
               mon_ack = exp_ack.pop_front();
               if (got.size() != mon_len) begin
                  errors++;
                  $display("FAIL frame_len: got %0d expected %0d", got.size(), mon_len);
               end
               checks++;
               if (ack_err !== mon_ack) begin
                  errors++;
                  $display("FAIL ack_err: got %0b expected %0b", ack_err, mon_ack);
               end
               checks++;
               if (busy !== 1'b0) begin
                  errors++;
                  $display("FAIL busy_at_done: got %0b expected 0", busy);
               end
            end
            last_frame = got;
            got.delete();
            frames_done++;
         end
      end
   end

   // Reference frame: raw bits, then stuffing over the raw region, then tail
   function automatic void build_model(input logic [10:0] i, input logic [3:0] d,
                                       input logic [63:0] dt, input logic [14:0] c);
      int nb;
      int run;
      bit last;
      model_raw.delete();
      model_tx.delete();
      model_stuff = 0;
      model_raw.push_back(1'b0);
      for (int k = 10; k >= 0; k--) model_raw.push_back(i[k]);
      model_raw.push_back(1'b0);
      model_raw.push_back(1'b0);
      model_raw.push_back(1'b0);
      for (int k = 3; k >= 0; k--) model_raw.push_back(d[k]);
      nb = (d > 4'd8) ? 64 : 8 * int'(d);
      for (int k = 0; k < nb; k++) model_raw.push_back(dt[63-k]);
      for (int k = 14; k >= 0; k--) model_raw.push_back(c[k]);
      run  = 0;
      last = 1'b0;
      foreach (model_raw[k]) begin
         model_tx.push_back(model_raw[k]);
         if (run > 0 && model_raw[k] == last) run++;
         else run = 1;
         last = model_raw[k];
         if (run == STUFF_LEN) begin
            model_tx.push_back(~last);
            last = ~last;
            run  = 1;
            model_stuff++;
         end
      end
      for (int k = 0; k < TAIL_BITS; k++) model_tx.push_back(1'b1);
   endfunction

   // Remove stuff bits from the captured frame over its first raw_len bits
   function automatic void destuff(input int raw_len);
      int run;
      bit last;
      int k;
      destuffed.delete();
      run  = 0;
      last = 1'b0;
      k    = 0;
      while (k < last_frame.size()) begin
         if (destuffed.size() < raw_len) begin
            destuffed.push_back(last_frame[k]);
            if (run > 0 && last_frame[k] == last) run++;
            else run = 1;
            last = last_frame[k];
            if (run == STUFF_LEN) begin
               k++;
               run  = 1;
               last = ~last;
            end
         end else begin
            destuffed.push_back(last_frame[k]);
         end
         k++;
      end
   endfunction

   function automatic int count_raw_mism();
      int m;
      m = 0;
      foreach (model_raw[k]) begin
         if (k >= destuffed.size() || destuffed[k] != model_raw[k]) m++;
      end
      return m;
   endfunction

   function automatic int count_ref_mism();
      int m;
      m = (last_frame.size() > ref_frame.size()) ? last_frame.size() - ref_frame.size()
                                                 : ref_frame.size() - last_frame.size();
      foreach (ref_frame[k]) begin
         if (k < last_frame.size() && last_frame[k] != ref_frame[k]) m++;
      end
      return m;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // Push expectations, then present the frame request for one cycle
   task automatic send(input logic [10:0] i, input logic [3:0] d, input logic [63:0] dt,
                       input logic [14:0] c, input logic rxv);
      build_model(i, d, dt, c);
      foreach (model_tx[k]) exp_bits.push_back(model_tx[k]);
      exp_len.push_back(model_tx.size());
      exp_ack.push_back(rxv);
      id     = i;
      dlc    = d;
      data   = dt;
      crc_in = c;
      rx     = rxv;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Returns on the falling edge inside the done cycle
   task automatic wait_done(input int budget);
      int  n0;
      bit  seen;
      n0   = frames_done;
      seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         if (frames_done != n0) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL timeout: no done within %0d cycles", budget);
      end
   endtask

   logic [11:0] pre_val;
   logic [11:0] pre_exp;
   logic [10:0] idv;
   logic [3:0]  dlcv;
   bit          any_done;
   int          n_before;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_tx", tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_ack_err", ack_err, 0);
      rst = 1'b0;
      @(negedge clk);

      // All-zero frame: stuff after every five zeros
      send(11'h000, 4'h0, 64'h0, 15'h0000, 1'b0);
      wait_done(4000);
      chk("zero_len", last_frame.size(), 53);
      pre_val = '0;
      for (int k = 0; k < 12; k++) pre_val = {pre_val[10:0], last_frame[k]};
      pre_exp = 12'b000001000001;
      chk("zero_prefix", pre_val, pre_exp);

      // CRC ending in five ones: stuff bit before CRC_DEL
      send(11'h000, 4'h0, 64'h0, 15'h001F, 1'b0);
      wait_done(4000);
      chk("crc1f_len", last_frame.size(), 53);
      chk("crc1f_last_crc", last_frame[38], 1);
      chk("crc1f_stuff", last_frame[39], 0);
      chk("crc1f_crc_del", last_frame[40], 1);

      // Full payload
      send(11'h7FF, 4'h8, 64'h0123456789ABCDEF, 15'h4A5B, 1'b0);
      wait_done(4000);
      destuff(98);
      chk("full_destuff_len", destuffed.size(), 111);
      chk("full_raw_mism", count_raw_mism(), 0);
      chk("full_stuff_cnt", last_frame.size() - 111, model_stuff);
      idv = '0;
      for (int k = 1; k <= 11; k++) idv = {idv[9:0], destuffed[k]};
      chk("full_id", idv, 11'h7FF);

      // dlc 15 carries 8 bytes
      send(11'h123, 4'hF, 64'hFEDCBA9876543210, 15'h2C3D, 1'b0);
      wait_done(4000);
      destuff(98);
      chk("dlcF_destuff_len", destuffed.size(), 111);
      dlcv = '0;
      for (int k = 15; k <= 18; k++) dlcv = {dlcv[2:0], destuffed[k]};
      chk("dlcF_field", dlcv, 4'hF);
      chk("dlcF_raw_mism", count_raw_mism(), 0);

      // ACK slot recessive, then held until next start
      send(11'h055, 4'h1, 64'hA500000000000000, 15'h1234, 1'b1);
      wait_done(4000);
      repeat (20) @(negedge clk);
      chk("ack_err_hold", ack_err, 1);
      send(11'h2AA, 4'h2, 64'h5AC3000000000000, 15'h0F0F, 1'b0);
      chk("ack_err_clr", ack_err, 0);
      chk("busy_after_start", busy, 1);

      // start while busy is ignored
      repeat (30) @(negedge clk);
      id    = 11'h7AA;
      dlc   = 4'h3;
      data  = 64'hFFFFFFFFFFFFFFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(4000);

      // start in the done cycle
      send(11'h3C1, 4'h1, 64'h8100000000000000, 15'h7001, 1'b0);
      wait_done(4000);
      chk("b2b_done_high", done, 1);
      send(11'h00F, 4'h2, 64'hF00F000000000000, 15'h0001, 1'b0);
      wait_done(4000);
      chk("frames_after_b2b", frames_done, 8);

      // Irregular tick spacing: identical bit sequence
      send(11'h4B2, 4'h2, 64'h3CC3000000000000, 15'h1A2B, 1'b0);
      wait_done(4000);
      ref_frame = last_frame;
      spacing = 3;
      send(11'h4B2, 4'h2, 64'h3CC3000000000000, 15'h1A2B, 1'b0);
      wait_done(8000);
      chk("spacing3_same", count_ref_mism(), 0);
      spacing = 17;
      send(11'h4B2, 4'h2, 64'h3CC3000000000000, 15'h1A2B, 1'b0);
      wait_done(30000);
      chk("spacing17_same", count_ref_mism(), 0);
      spacing = 0;
      send(11'h4B2, 4'h2, 64'h3CC3000000000000, 15'h1A2B, 1'b0);
      wait_done(30000);
      chk("spacing_mix_same", count_ref_mism(), 0);
      spacing = 1;

      // Reset mid-frame (inside DATA)
      send(11'h7FF, 4'h8, 64'h0123456789ABCDEF, 15'h4A5B, 1'b0);
      repeat (30) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_tx", tx, 1);
      chk("midrst_busy", busy, 0);
      exp_bits.delete();
      exp_len.delete();
      exp_ack.delete();
      @(negedge clk);
      rst = 1'b0;
      n_before = frames_done;
      any_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) any_done = 1'b1;
      end
      chk("midrst_no_done", any_done, 0);
      chk("midrst_frames", frames_done - n_before, 0);
      send(11'h7FF, 4'h8, 64'h0123456789ABCDEF, 15'h4A5B, 1'b0);
      wait_done(4000);
      destuff(98);
      chk("after_rst_raw_mism", count_raw_mism(), 0);
      chk("after_rst_len", destuffed.size(), 111);

      repeat (5) @(negedge clk);
      chk("exp_drained", exp_bits.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
